// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer
// Front-end for the repeated-subtraction GCD core. It accepts an operand
// pair on a valid/ready input, clears the core, serializes A then B onto the
// core's shared data bus with a start strobe, waits for done and presents the
// captured result on a valid/ready output. Pairs with a zero operand never
// reach the core (the subtraction loop would not terminate); their result is
// produced locally as a|b.
//
// Optional feature: define GCD_TIMEOUT_EN to add a watchdog on the WAIT state.
// After TIMEOUT_CYCLES WAIT cycles without done, the job completes with
// out_gcd=0 and out_timeout=1. Without the macro WAIT waits indefinitely and
// out_timeout is tied low.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake, in_a/in_b operands
//   core_clr            one-cycle clear to the core controller (held in reset)
//   core_start          start strobe, high while A is on core_data
//   core_data           core dataIn bus (A, then B held through WAIT)
//   core_done           core done level, core_result core Aout
//   out_valid/out_ready result handshake
//   out_gcd             result, out_zero zero-bypass flag, out_timeout watchdog flag
//
// state  | meaning
// IDLE   | ready for a new operand pair
// CLR    | core_clr pulse, returns core to its load state
// LOAD_A | A on core_data with core_start
// LOAD_B | B on core_data
// WAIT   | waiting for core_done (first 2 cycles ignore done)
// HOLD   | result presented until out_ready

module gcd_job_sequencer #(
    parameter int W              = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         core_clr,
    output logic         core_start,
    output logic [W-1:0] core_data,
    input  logic         core_done,
    input  logic [W-1:0] core_result,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_gcd,
    output logic         out_zero,
    output logic         out_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD_A,
        S_LOAD_B,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t       state;
    logic [W-1:0] a_q;
    logic [W-1:0] b_q;
    // Masks a done level left over from the previous job while the core
    // controller is still coming out of its clear.
    logic [1:0]   mask_cnt;

`ifdef GCD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_cnt;
    logic          timeout_q;
    assign out_timeout = timeout_q;
`else
    assign out_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            core_clr   <= 1'b1;
            core_start <= 1'b0;
            core_data  <= '0;
            out_valid  <= 1'b0;
            out_gcd    <= '0;
            out_zero   <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            mask_cnt   <= '0;
`ifdef GCD_TIMEOUT_EN
            wd_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            core_clr   <= 1'b0;
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        if (in_a == '0 || in_b == '0) begin
                            // gcd(0,x)=x and gcd(0,0)=0, so OR gives the answer
                            out_gcd   <= in_a | in_b;
                            out_zero  <= 1'b1;
                            out_valid <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                            timeout_q <= 1'b0;
`endif
                            state     <= S_HOLD;
                        end else begin
                            core_clr <= 1'b1;
                            state    <= S_CLR;
                        end
                    end
                end
                S_CLR: begin
                    core_data  <= a_q;
                    core_start <= 1'b1;
                    state      <= S_LOAD_A;
                end
                S_LOAD_A: begin
                    core_data <= b_q;
                    state     <= S_LOAD_B;
                end
                S_LOAD_B: begin
                    mask_cnt <= 2'd2;
`ifdef GCD_TIMEOUT_EN
                    wd_cnt   <= CW'(TIMEOUT_CYCLES - 1);
`endif
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (mask_cnt == 2'd0 && core_done) begin
                        out_gcd   <= core_result;
                        out_zero  <= 1'b0;
                        out_valid <= 1'b1;
`ifdef GCD_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state     <= S_HOLD;
                    end
`ifdef GCD_TIMEOUT_EN
                    else if (wd_cnt == '0) begin
                        out_gcd   <= '0;
                        out_zero  <= 1'b0;
                        out_valid <= 1'b1;
                        timeout_q <= 1'b1;
                        state     <= S_HOLD;
                    end
`endif
                    else begin
                        if (mask_cnt != 2'd0) begin
                            mask_cnt <= mask_cnt - 2'd1;
                        end
`ifdef GCD_TIMEOUT_EN
                        wd_cnt <= wd_cnt - 1'b1;
`endif
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
